// File: rtl/stat_graph_render_pkg.sv
// stat_graph_render_pkg: screen geometry and pixel types shared by the HUD graph files
package stat_graph_render_pkg;
  localparam int SCREEN_WIDTH = 1280;
  localparam int SCREEN_HEIGHT = 720;
  typedef logic [10:0] hcount_t;
  typedef logic [9:0] vcount_t;
  typedef logic [11:0] rgb_t;
endpackage

// File: rtl/stat_graph_render_hist.sv
// stat_graph_render_hist: tally history array, one sync write port, one registered read port, bulk clear
module stat_graph_render_hist #(
  parameter int DEPTH = 25,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  always_ff @(posedge clk_i) begin
    rdata_q <= !rst_n_i ? '0 : mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/stat_graph_render.sv
// stat_graph_render: samples per-channel event tallies into a scrolling, auto-scaled HUD graph
module stat_graph_render
  import stat_graph_render_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int HISTORY_LEN = 25,
  parameter int LOG_SAMPLE_PIX = 3,
  parameter int GRAPH_W = 200,
  parameter int GRAPH_H = 200,
  parameter int ORIGIN_X = 800,
  parameter int ORIGIN_Y = 32,
  parameter int SAMPLE_PERIOD = 32,
  parameter int CNT_W = 16,
  parameter logic [NUM_CH*12-1:0] CH_COLOR = 24'h0F0_F00
) (
  input  logic              clk_130mhz,
  input  logic              rst_n_in,
  input  hcount_t           hcount_in,
  input  vcount_t           vcount_in,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              count_en_in,
  input  logic              clear_in,
  output rgb_t              pix_out
);
  localparam int PW = (HISTORY_LEN > 1) ? $clog2(HISTORY_LEN) : 1;
  localparam int FW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int SW = $clog2(CNT_W + 1);
  localparam int DW = NUM_CH * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SW-1:0] log_scale_q, log_scale_d, fit_scale;
  logic [CNT_W-1:0] acc_q [NUM_CH];
  logic [CNT_W-1:0] acc_d [NUM_CH];
  logic [CNT_W-1:0] acc_inc [NUM_CH];
  logic [DW-1:0] push_data, rd_data;
  logic frame_end, sample_frame, push, fits;
  logic [10:0] idx;
  logic [PW:0] slot_sum;
  logic [PW-1:0] slot, raddr;
  logic col_valid;
  hcount_t h1_q;
  vcount_t v1_q;
  logic valid1_q;
  logic x_axis, y_axis;
  logic [CNT_W-1:0] shifted;
  logic [31:0] height;
  rgb_t pix_d, pix_q;
  assign frame_end = hcount_in == 11'(SCREEN_WIDTH - 1) && vcount_in == 10'(SCREEN_HEIGHT - 1);
  assign sample_frame = frame_cnt_q == '0;
  assign push = frame_end && sample_frame && !clear_in;
  // acc_inc already holds the frame-end cycle's event, so it is what gets pushed
  always_comb begin
    push_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_inc[c] = (sample_frame && count_en_in && event_in[c] && acc_q[c] != CNT_MAX) ? acc_q[c] + CNT_W'(1) : acc_q[c];
      push_data[c*CNT_W +: CNT_W] = acc_inc[c];
      acc_d[c] = (clear_in || push) ? '0 : acc_inc[c];
    end
  end
  // descending scan leaves the smallest scale that fits every pushed tally
  always_comb begin
    fit_scale = SW'(CNT_W);
    fits = 1'b1;
    for (int s = CNT_W; s >= 0; s--) begin
      fits = 1'b1;
      for (int c = 0; c < NUM_CH; c++) fits = fits && (64'(acc_inc[c]) <= (64'(GRAPH_H) << s));
      fit_scale = fits ? SW'(s) : fit_scale;
    end
  end
  assign log_scale_d = clear_in ? '0 : (push && fit_scale > log_scale_q) ? fit_scale : log_scale_q;
  assign frame_cnt_d = clear_in ? '0 : !frame_end ? frame_cnt_q :
                       (frame_cnt_q == FW'(SAMPLE_PERIOD - 1)) ? '0 : frame_cnt_q + FW'(1);
  assign wr_ptr_d = clear_in ? '0 : !push ? wr_ptr_q :
                    (wr_ptr_q == PW'(HISTORY_LEN - 1)) ? '0 : wr_ptr_q + PW'(1);
  always_ff @(posedge clk_130mhz) begin
    if (!rst_n_in) begin
      frame_cnt_q <= '0;
      wr_ptr_q <= '0;
      log_scale_q <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      log_scale_q <= log_scale_d;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
    end
  end
  // leftmost column maps to wr_ptr, which always holds the oldest sample
  assign idx = (hcount_in - 11'(ORIGIN_X)) >> LOG_SAMPLE_PIX;
  assign col_valid = hcount_in >= 11'(ORIGIN_X) && 32'(idx) < HISTORY_LEN;
  assign slot_sum = {1'b0, wr_ptr_q} + (PW+1)'(idx);
  assign slot = (slot_sum >= (PW+1)'(HISTORY_LEN)) ? PW'(slot_sum - (PW+1)'(HISTORY_LEN)) : PW'(slot_sum);
  assign raddr = col_valid ? slot : '0;
  stat_graph_render_hist #(
    .DEPTH(HISTORY_LEN),
    .WIDTH(DW)
  ) u_hist (
    .clk_i  (clk_130mhz),
    .rst_n_i(rst_n_in),
    .clear_i(clear_in),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(push_data),
    .raddr_i(raddr),
    .rdata_o(rd_data)
  );
  assign x_axis = v1_q == 10'(ORIGIN_Y + GRAPH_H) && h1_q >= 11'(ORIGIN_X) && h1_q < 11'(ORIGIN_X + GRAPH_W);
  assign y_axis = h1_q == 11'(ORIGIN_X) && v1_q >= 10'(ORIGIN_Y) && v1_q <= 10'(ORIGIN_Y + GRAPH_H);
  always_comb begin
    pix_d = '0;
    shifted = '0;
    height = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      shifted = rd_data[c*CNT_W +: CNT_W] >> log_scale_q;
      height = (32'(shifted) > 32'(GRAPH_H)) ? 32'(GRAPH_H) : 32'(shifted);
      pix_d = (valid1_q && 32'(v1_q) + height == 32'(ORIGIN_Y + GRAPH_H)) ? CH_COLOR[c*12 +: 12] : pix_d;
    end
    pix_d = (x_axis || y_axis) ? 12'hFFF : pix_d;
  end
  always_ff @(posedge clk_130mhz) begin
    if (!rst_n_in) begin
      h1_q <= '0;
      v1_q <= '0;
      valid1_q <= 1'b0;
      pix_q <= '0;
    end else begin
      h1_q <= hcount_in;
      v1_q <= vcount_in;
      valid1_q <= col_valid;
      pix_q <= pix_d;
    end
  end
  assign pix_out = pix_q;
endmodule

// File: tb/tb_stat_graph_render.sv
// tb_stat_graph_render: randomized self-checking bench against a shift-register model of the graph
module tb_stat_graph_render;
  import stat_graph_render_pkg::*;
  localparam int NCH = 2, HL = 25, GW = 200, GH = 200, OX = 800, OY = 32, SP = 32, CW = 12;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [11:0] COL0 = 12'hF00, COL1 = 12'h0F0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hcount_t hc = '0;
  vcount_t vc = '0;
  logic [1:0] ev_i = '0;
  logic en_i = 1'b0;
  logic clr_i = 1'b0;
  rgb_t pix;
  int n_checks = 0;
  int n_fail = 0;
  int m_hist [HL][NCH];
  int m_acc [NCH];
  int m_frame;
  int m_max;
  logic [11:0] exp_q [$];
  string tag_q [$];
  always #4 clk = ~clk;
  stat_graph_render #(
    .CNT_W(CW),
    .CH_COLOR({COL1, COL0})
  ) dut (
    .clk_130mhz (clk),
    .rst_n_in   (rst_n),
    .hcount_in  (hc),
    .vcount_in  (vc),
    .event_in   (ev_i),
    .count_en_in(en_i),
    .clear_in   (clr_i),
    .pix_out    (pix)
  );
  task automatic check(string tag, logic [11:0] got, logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void m_clear();
    for (int i = 0; i < HL; i++) for (int c = 0; c < NCH; c++) m_hist[i][c] = 0;
    for (int c = 0; c < NCH; c++) m_acc[c] = 0;
    m_frame = 0;
    m_max = 0;
  endfunction
  function automatic int m_scale();
    int s = 0;
    while (m_max > (GH << s)) s++;
    return s;
  endfunction
  function automatic int m_ht(int i, int c);
    int t = m_hist[i][c] >> m_scale();
    return t > GH ? GH : t;
  endfunction
  function automatic logic [11:0] exp_pix(int h, int v);
    if (v == OY + GH && h >= OX && h < OX + GW) return 12'hFFF;
    if (h == OX && v >= OY && v <= OY + GH) return 12'hFFF;
    if (h < OX || (h - OX) / 8 >= HL) return 12'h000;
    for (int c = 0; c < NCH; c++)
      if (v == OY + GH - m_ht((h - OX) / 8, c)) return c == 0 ? COL0 : COL1;
    return 12'h000;
  endfunction
  task automatic cyc(int h, int v, logic [1:0] ev, logic en, logic clr);
    hc = 11'(h);
    vc = 10'(v);
    ev_i = ev;
    en_i = en;
    clr_i = clr;
    if (!rst_n || clr) m_clear();
    else begin
      if (m_frame == 0)
        for (int c = 0; c < NCH; c++) if (ev[c] && en && m_acc[c] < CMAX) m_acc[c]++;
      if (h == SCREEN_WIDTH - 1 && v == SCREEN_HEIGHT - 1) begin
        if (m_frame == 0) begin
          for (int i = 0; i < HL - 1; i++) for (int c = 0; c < NCH; c++) m_hist[i][c] = m_hist[i+1][c];
          for (int c = 0; c < NCH; c++) begin
            m_hist[HL-1][c] = m_acc[c];
            if (m_acc[c] > m_max) m_max = m_acc[c];
            m_acc[c] = 0;
          end
        end
        m_frame = (m_frame + 1) % SP;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic probe_exp(int h, int v, logic [11:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back($sformatf("pix(%0d,%0d)", h, v));
    cyc(h, v, 2'($urandom), 1'b0, 1'b0);
    if (exp_q.size() == 2) check(tag_q.pop_front(), pix, exp_q.pop_front());
  endtask
  task automatic probe(int h, int v);
    probe_exp(h, v, exp_pix(h, v));
  endtask
  task automatic flush();
    cyc(0, 0, 2'b00, 1'b0, 1'b0);
    while (exp_q.size() > 0) check(tag_q.pop_front(), pix, exp_q.pop_front());
  endtask
  task automatic events(int n, logic [1:0] ev, logic en);
    for (int i = 0; i < n; i++) cyc(int'($urandom_range(1200, 0)), int'($urandom_range(700, 0)), ev, en, 1'b0);
  endtask
  task automatic events_rand(int n);
    for (int i = 0; i < n; i++) events(1, 2'($urandom), 1'($urandom));
  endtask
  task automatic frame_end(logic [1:0] ev, logic en, logic clr);
    cyc(SCREEN_WIDTH - 1, SCREEN_HEIGHT - 1, ev, en, clr);
  endtask
  task automatic advance();
    while (m_frame != 0) frame_end(2'($urandom), 1'($urandom), 1'b0);
  endtask
  task automatic scan(int nrand);
    for (int i = 0; i < HL; i++) begin
      for (int c = 0; c < NCH; c++) probe(OX + i * 8 + int'($urandom_range(7, 0)), OY + GH - m_ht(i, c));
      probe(OX + i * 8 + int'($urandom_range(7, 0)), int'($urandom_range(OY + GH + 3, OY - 3)));
    end
    for (int i = 0; i < nrand; i++)
      probe(int'($urandom_range(OX + GW + 4, OX - 4)), int'($urandom_range(OY + GH + 4, OY - 4)));
    flush();
  endtask
  initial begin
    m_clear();
    repeat (3) cyc(0, 0, 2'b00, 1'b0, 1'b0);
    check("reset_pix", pix, 12'h000);
    rst_n = 1'b1;
    probe_exp(800, 232, 12'hFFF);
    probe_exp(801, 100, 12'h000);
    flush();
    events(150, 2'b01, 1'b1);
    events(40, 2'b11, 1'b0);
    frame_end(2'b00, 1'b0, 1'b0);
    advance();
    probe_exp(995, 82, COL0);
    probe_exp(995, 232, 12'hFFF);
    flush();
    scan(10);
    events(1000, 2'b11, 1'b1);
    frame_end(2'b00, 1'b0, 1'b0);
    advance();
    probe_exp(995, 107, COL0);
    flush();
    events(4200, 2'b11, 1'b1);
    frame_end(2'b00, 1'b0, 1'b0);
    advance();
    probe_exp(995, 105, COL0);
    probe_exp(987, 201, COL0);
    flush();
    scan(10);
    cyc(5, 5, 2'b00, 1'b0, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      events(k / 2, 2'b11, 1'b1);
      events(k - k / 2, 2'b01, 1'b1);
      frame_end(2'b00, 1'b0, 1'b0);
      advance();
    end
    probe_exp(803, 230, COL0);
    probe_exp(995, 206, COL0);
    flush();
    scan(10);
    events(60, 2'b11, 1'b1);
    frame_end(2'b00, 1'b0, 1'b0);
    advance();
    frame_end(2'b00, 1'b0, 1'b0);
    advance();
    probe_exp(987, 172, COL0);
    probe_exp(995, 232, 12'hFFF);
    flush();
    scan(10);
    events(50, 2'b11, 1'b1);
    frame_end(2'b11, 1'b1, 1'b1);
    probe_exp(995, 232, 12'hFFF);
    probe_exp(995, 182, 12'h000);
    flush();
    scan(10);
    events(30, 2'b01, 1'b1);
    frame_end(2'b00, 1'b0, 1'b0);
    repeat (4) frame_end(2'b11, 1'b1, 1'b0);
    events(100, 2'b11, 1'b1);
    advance();
    events(10, 2'b01, 1'b1);
    frame_end(2'b00, 1'b0, 1'b0);
    advance();
    probe_exp(995, 222, COL0);
    probe_exp(987, 202, COL0);
    flush();
    scan(10);
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(3, 0) == 0) cyc(3, 3, 2'b00, 1'b0, 1'b1);
      advance();
      events_rand(int'($urandom_range(600, 0)));
      frame_end(2'($urandom), 1'($urandom), 1'b0);
      advance();
      scan(20);
    end
    events(20, 2'b11, 1'b1);
    rst_n = 1'b0;
    cyc(995, 232, 2'b00, 1'b0, 1'b0);
    check("mid_reset_pix", pix, 12'h000);
    rst_n = 1'b1;
    cyc(800, 232, 2'b00, 1'b0, 1'b0);
    check("refill_1clk", pix, 12'h000);
    cyc(0, 0, 2'b00, 1'b0, 1'b0);
    check("refill_2clk", pix, 12'hFFF);
    scan(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
